// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: synchronise and filter the PS/2 pins, decode 11-bit frames,
// fold E0/F0 prefixes into flags and queue key events in a first-word-fall-through FIFO.
module ps2_kbd_rx_fifo #(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                  clk,
    input  logic                                  ar,
    input  logic                                  ps2_clk,
    input  logic                                  ps2_dat,
    output logic [7:0]                            ev_code,
    output logic                                  ev_ext,
    output logic                                  ev_brk,
    output logic                                  ev_valid,
    input  logic                                  ev_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count,
    output logic                                  err_parity,
    output logic                                  err_frame,
    output logic                                  overflow
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Odd parity over data byte plus parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic                clk_meta_r;
    logic                clk_sync_r;
    logic                dat_meta_r;
    logic                dat_sync_r;
    logic [FILT_LEN-1:0] filt_sr_r;
    logic                filt_clk_r;
    logic                filt_nxt_s;
    logic                strobe_r;

    state_t              state_r;
    logic [2:0]          bit_cnt_r;
    logic [7:0]          shift_r;
    logic                par_r;
    logic [TW-1:0]       tcnt_r;
    logic                ext_pend_r;
    logic                brk_pend_r;
    logic                err_parity_r;
    logic                err_frame_r;

    logic                frame_good_s;
    logic                is_e0_s;
    logic                is_f0_s;
    logic                push_s;
    logic                timeout_s;

    logic [9:0]          mem_r [FIFO_DEPTH];
    logic [PW-1:0]       rd_ptr_r;
    logic [PW-1:0]       wr_ptr_r;
    logic [CW-1:0]       count_r;
    logic                valid_r;
    logic [9:0]          head_r;
    logic                overflow_r;

    logic                pop_s;
    logic                full_s;
    logic                wr_en_s;
    logic                ovf_s;
    logic [PW-1:0]       rd_nxt_s;
    logic [CW-1:0]       count_nxt_s;
    logic [9:0]          push_data_s;
    logic [9:0]          head_nxt_s;

    // Two-flop synchronisers; the idle PS/2 line level is high.
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= ps2_clk;
            clk_sync_r <= clk_meta_r;
            dat_meta_r <= ps2_dat;
            dat_sync_r <= dat_meta_r;
        end
    end

    // Filtered clock only changes once the whole window agrees.
    always_comb begin
        filt_nxt_s = filt_clk_r;
        if (&filt_sr_r) begin
            filt_nxt_s = 1'b1;
        end else if (~|filt_sr_r) begin
            filt_nxt_s = 1'b0;
        end else begin
            filt_nxt_s = filt_clk_r;
        end
    end

    // Glitch filter shift register and falling-edge sample strobe.
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            filt_sr_r  <= {FILT_LEN{1'b1}};
            filt_clk_r <= 1'b1;
            strobe_r   <= 1'b0;
        end else begin
            filt_sr_r  <= {filt_sr_r[FILT_LEN-2:0], clk_sync_r};
            filt_clk_r <= filt_nxt_s;
            strobe_r   <= filt_clk_r & ~filt_nxt_s;
        end
    end

    // Frame evaluation on the STOP strobe; a strobe beats a coincident timeout.
    always_comb begin
        frame_good_s = dat_sync_r & odd_parity_ok(shift_r, par_r);
        is_e0_s      = (shift_r == 8'hE0);
        is_f0_s      = (shift_r == 8'hF0);
        push_s       = strobe_r && (state_r == STOP) && frame_good_s && !is_e0_s && !is_f0_s;
        timeout_s    = (state_r != IDLE) && !strobe_r && (tcnt_r == TW'(TIMEOUT_CYC - 1));
    end

    // Frame FSM, timeout counter, prefix flags and error pulses.
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            state_r      <= IDLE;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            par_r        <= 1'b0;
            tcnt_r       <= '0;
            ext_pend_r   <= 1'b0;
            brk_pend_r   <= 1'b0;
            err_parity_r <= 1'b0;
            err_frame_r  <= 1'b0;
        end else begin
            err_parity_r <= 1'b0;
            err_frame_r  <= 1'b0;
            if (strobe_r || (state_r == IDLE) || timeout_s) begin
                tcnt_r <= '0;
            end else begin
                tcnt_r <= tcnt_r + TW'(1);
            end
            if (strobe_r) begin
                case (state_r)
                    IDLE: begin
                        if (!dat_sync_r) begin
                            state_r   <= DATA;
                            bit_cnt_r <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift_r   <= {dat_sync_r, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_r   <= dat_sync_r;
                        state_r <= STOP;
                    end
                    STOP: begin
                        state_r <= IDLE;
                        if (!frame_good_s) begin
                            err_parity_r <= 1'b1;
                            ext_pend_r   <= 1'b0;
                            brk_pend_r   <= 1'b0;
                        end else if (is_e0_s) begin
                            ext_pend_r <= 1'b1;
                        end else if (is_f0_s) begin
                            brk_pend_r <= 1'b1;
                        end else begin
                            ext_pend_r <= 1'b0;
                            brk_pend_r <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end else if (timeout_s) begin
                state_r     <= IDLE;
                shift_r     <= 8'h00;
                err_frame_r <= 1'b1;
                ext_pend_r  <= 1'b0;
                brk_pend_r  <= 1'b0;
            end
        end
    end

    // FIFO control; the head register is preloaded with whatever sits at the next read slot.
    always_comb begin
        pop_s       = valid_r & ev_ready;
        full_s      = (count_r == CW'(FIFO_DEPTH));
        wr_en_s     = push_s && (!full_s || pop_s);
        ovf_s       = push_s && full_s && !pop_s;
        push_data_s = {ext_pend_r, brk_pend_r, shift_r};
        rd_nxt_s    = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
        case ({wr_en_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
        if (count_nxt_s == '0) begin
            head_nxt_s = 10'd0;
        end else if (wr_en_s && (rd_nxt_s == wr_ptr_r)) begin
            head_nxt_s = push_data_s;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // Event storage.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
        end
    end

    // FIFO pointers, occupancy and registered head outputs.
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
            valid_r    <= 1'b0;
            head_r     <= 10'd0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            rd_ptr_r   <= rd_nxt_s;
            count_r    <= count_nxt_s;
            valid_r    <= (count_nxt_s != '0);
            head_r     <= head_nxt_s;
            overflow_r <= ovf_s;
        end
    end

    assign ev_code    = head_r[7:0];
    assign ev_brk     = head_r[8];
    assign ev_ext     = head_r[9];
    assign ev_valid   = valid_r;
    assign fifo_count = count_r;
    assign err_parity = err_parity_r;
    assign err_frame  = err_frame_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
// Directed bench for ps2_kbd_rx_fifo: bit-banged PS/2 frames with hand-computed expected events.
module tb_ps2_kbd_rx_fifo;

    localparam int FILT_LEN    = 8;
    localparam int TIMEOUT_CYC = 200;
    localparam int FIFO_DEPTH  = 4;

    logic       clk = 1'b0;
    logic       ar;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;
    logic       ev_valid;
    logic       ev_ready;
    logic [2:0] fifo_count;
    logic       err_parity;
    logic       err_frame;
    logic       overflow;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int last_fall = 0;
    int n_par  = 0;
    int n_frm  = 0;
    int n_ovf  = 0;

    ps2_kbd_rx_fifo #(
        .FILT_LEN   (FILT_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .ar        (ar),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_brk    (ev_brk),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .fifo_count(fifo_count),
        .err_parity(err_parity),
        .err_frame (err_frame),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (err_parity === 1'b1) n_par <= n_par + 1;
        if (err_frame === 1'b1)  n_frm <= n_frm + 1;
        if (overflow === 1'b1)   n_ovf <= n_ovf + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall = cyc;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ flip);
        ps2_bit(stop);
        ps2_dat = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic pop_one();
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    task automatic check_event(input string tag, input logic [7:0] code, input logic ext, input logic brk);
        check({tag, "_valid"}, {31'd0, ev_valid}, 32'd1);
        check({tag, "_code"}, {24'd0, ev_code}, {24'd0, code});
        check({tag, "_flags"}, {30'd0, ev_ext, ev_brk}, {30'd0, ext, brk});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0;
        int d;
        ar = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        ev_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_valid", {31'd0, ev_valid}, 32'd0);
        check("rst_out", {19'd0, ev_code, ev_ext, ev_brk, fifo_count}, 32'd0);
        check("rst_pulses", {29'd0, err_parity, err_frame, overflow}, 32'd0);
        ar = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame, then pop
        send_frame(8'h1C, 1'b0, 1'b1);
        check_event("f1c", 8'h1C, 1'b0, 1'b0);
        check("f1c_count", {29'd0, fifo_count}, 32'd1);
        pop_one();
        check("f1c_pop_valid", {31'd0, ev_valid}, 32'd0);
        check("f1c_pop_count", {29'd0, fifo_count}, 32'd0);
        check("f1c_pop_code", {24'd0, ev_code}, 32'd0);

        // Extended break: E0 F0 75
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        check("pfx_nopush", {31'd0, ev_valid}, 32'd0);
        send_frame(8'h75, 1'b0, 1'b1);
        check_event("e0f075", 8'h75, 1'b1, 1'b1);
        check("e0f075_count", {29'd0, fifo_count}, 32'd1);
        pop_one();
        send_frame(8'h16, 1'b0, 1'b1);
        check_event("after_pfx", 8'h16, 1'b0, 1'b0);
        pop_one();

        // Parity and stop errors
        send_frame(8'h16, 1'b1, 1'b1);
        check("par_err_cnt", n_par, 32'd1);
        check("par_err_noev", {31'd0, ev_valid}, 32'd0);
        send_frame(8'h1E, 1'b0, 1'b1);
        check_event("after_par", 8'h1E, 1'b0, 1'b0);
        pop_one();
        send_frame(8'h1E, 1'b0, 1'b0);
        check("stop_err_cnt", n_par, 32'd2);
        check("stop_err_noev", {31'd0, ev_valid}, 32'd0);

        // Fill past depth
        send_frame(8'h16, 1'b0, 1'b1);
        send_frame(8'h1E, 1'b0, 1'b1);
        send_frame(8'h26, 1'b0, 1'b1);
        send_frame(8'h25, 1'b0, 1'b1);
        check("full_ovf0", n_ovf, 32'd0);
        send_frame(8'h2E, 1'b0, 1'b1);
        check("full_count", {29'd0, fifo_count}, 32'd4);
        check("full_ovf1", n_ovf, 32'd1);
        check_event("pop0", 8'h16, 1'b0, 1'b0);
        pop_one();
        check_event("pop1", 8'h1E, 1'b0, 1'b0);
        pop_one();
        check_event("pop2", 8'h26, 1'b0, 1'b0);
        pop_one();
        check_event("pop3", 8'h25, 1'b0, 1'b0);
        check("pop3_count", {29'd0, fifo_count}, 32'd1);
        pop_one();
        check("drained", {28'd0, ev_valid, fifo_count}, 32'd0);

        // Timeout mid-frame
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        p0 = last_fall;
        for (int i = 0; i < 2 * TIMEOUT_CYC && err_frame !== 1'b1; i++) @(negedge clk);
        d = cyc - p0;
        check("tmo_seen", {31'd0, err_frame}, 32'd1);
        check("tmo_window", {31'd0, (d >= TIMEOUT_CYC) && (d <= TIMEOUT_CYC + FILT_LEN + 8)}, 32'd1);
        repeat (20) @(negedge clk);
        check("tmo_pulses", n_frm, 32'd1);
        check("tmo_noev", {31'd0, ev_valid}, 32'd0);
        send_frame(8'h45, 1'b0, 1'b1);
        check_event("after_tmo", 8'h45, 1'b0, 1'b0);
        pop_one();

        // Short clock glitch with data low must not start a frame
        ps2_dat = 1'b0;
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (2 * TIMEOUT_CYC) @(negedge clk);
        check("glitch_nofrm", n_frm, 32'd1);
        check("glitch_noev", {31'd0, ev_valid}, 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1);
        check_event("after_glitch", 8'h1C, 1'b0, 1'b0);

        // Reset mid-frame with an event queued and a prefix pending
        send_frame(8'hE0, 1'b0, 1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ar = 1'b0;
        #1;
        check("mrst_out", {18'd0, ev_valid, ev_code, ev_ext, ev_brk, fifo_count}, 32'd0);
        repeat (5) @(negedge clk);
        ar = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h1C, 1'b0, 1'b1);
        check_event("after_mrst", 8'h1C, 1'b0, 1'b0);
        check("after_mrst_cnt", {29'd0, fifo_count}, 32'd1);
        check("no_stray_frm", n_frm, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx_fifo.md
Name: ps2_kbd_rx_fifo

Overview:
- Parametrised next-generation PS/2 keyboard receiver.
- Filters the PS/2 clock, deserialises 11-bit frames, and checks start, parity and stop bits.
- Folds E0 (extended) and F0 (break) prefix bytes into flags on the following scan code.
- Queues completed key events in a first-word-fall-through FIFO with a valid/ready handshake, so the game logic consumes events at its own pace. It sits between the PS/2 pins and the game-control logic, on the system clock.

Parameters:
- FILT_LEN, 8: glitch-filter length in clk cycles (≥2).
- TIMEOUT_CYC, 100000: clk cycles without a PS/2 clock falling edge before a partial frame is abandoned (2 ms at 50 MHz).
- FIFO_DEPTH, 4: event FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  system clock, 25 or 50 MHz.
- ar  in  1  reset; asynchronous, active-low.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_dat  in  1  raw PS/2 data pin, asynchronous.
- ev_code  out  8  head-of-FIFO scan code.
- ev_ext  out  1  head event was preceded by E0.
- ev_brk  out  1  head event was preceded by F0 (key release).
- ev_valid  out  1  FIFO non-empty.
- ev_ready  in  1  consumer accepts the head event.
- fifo_count  out  clog2(FIFO_DEPTH+1)  occupancy.
- err_parity  out  1  1-cycle pulse: parity or stop-bit failure.
- err_frame  out  1  1-cycle pulse: timeout mid-frame.
- overflow  out  1  1-cycle pulse: event dropped because FIFO full.

Behaviour:
- Reset (ar=0, async): all outputs 0; FIFO empty; FSM in IDLE; prefix flags cleared; filter shift register all ones; filtered clock = 1.
- A reset mid-frame discards the partial frame and any pending prefix.
- Input conditioning: ps2_clk and ps2_dat each pass through a 2-flop synchroniser.
- Filter: the synchronised clock shifts into a FILT_LEN shift register.
  - Filtered clock goes 1 when the register is all ones, 0 when all zeros, and holds otherwise.
- A falling edge of the filtered clock produces a 1-cycle sample strobe; synchronised ps2_dat is captured on that cycle.
- FSM, advancing only on sample strobes:
  - IDLE: dat=0 → DATA, bit counter 0. dat=1 → stay (ignored).
  - DATA: shift dat in LSB-first; after the 8th bit → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: frame is good iff dat=1 and XOR(data[7:0], parity)=1 (odd parity).
    - Good: byte goes to the prefix stage.
    - Bad: err_parity pulses, byte is discarded, prefix flags are cleared.
    - Either way → IDLE.
- Timeout: a counter clears on every sample strobe and while in IDLE.
  - Outside IDLE, when it reaches TIMEOUT_CYC-1: err_frame pulses, FSM → IDLE, partial byte discarded, prefix flags cleared.
  - A sample strobe on the same cycle wins over the timeout.
- Prefix stage:
  - Byte E0 sets ext_pend; byte F0 sets brk_pend. Neither is pushed.
  - Any other byte pushes {ext_pend, brk_pend, byte} and clears both flags.
  - Prefixes may arrive in either order and are ORed.
- FIFO (first-word fall-through, FIFO_DEPTH×10 bits):
  - Push occurs the cycle after the STOP strobe. When the FIFO was empty, ev_valid rises on that same cycle with the head fields valid.
  - ev_code/ev_ext/ev_brk are forced to 0 while ev_valid=0.
  - Pop when ev_valid && ev_ready; the next entry appears on the following cycle.
  - Push while full without a pop: new event is dropped, overflow pulses, FIFO unchanged.
  - Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: the push proceeds only; pop is illegal because ev_valid=0.
  - Read and write pointers wrap modulo FIFO_DEPTH; fifo_count tracks exactly.
- Error pulses and overflow last exactly one clk cycle each; they are independent and may coincide.

Test Plan:
- Frame 0x1C with parity 0 and stop 1, ev_ready=0 → ev_valid=1, ev_code=0x1C, ev_ext=0, ev_brk=0, fifo_count=1; asserting ev_ready for 1 cycle → ev_valid=0, count 0.
- Frames E0, F0, 75 → exactly one event: ev_code=0x75, ev_ext=1, ev_brk=1. Then frame 0x16 → ev_ext=0, ev_brk=0.
- Frame 0x16 with parity flipped → one err_parity pulse, no event. Next good frame 0x1E → event 0x1E. Stop bit=0 on a frame → err_parity, no event.
- FIFO_DEPTH=4, ev_ready=0, frames 0x16, 0x1E, 0x26, 0x25, 0x2E → count=4 and one overflow pulse on the 5th. Popping yields 0x16, 0x1E, 0x26, 0x25 in order.
- Start bit plus 4 data bits, then idle → err_frame pulses exactly TIMEOUT_CYC cycles after the last strobe, FSM back in IDLE, no event. Subsequent frame 0x45 → event 0x45.
- With FILT_LEN=8, a 3-cycle low glitch on ps2_clk in IDLE → no sample strobe, no state change. Assert reset mid-frame → all outputs 0 immediately; next full frame decodes correctly.
